// File: rtl/fetch_stage_if_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if_if
// Purpose  : Instruction-memory req/ack bus between the IF stage and imem.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : IF pipe stage - PC, imem fetch handshake and IF/ID register.
// Revision : 1.0
// ============================================================================
module fetch_stage_if #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  wire                     clock,
    input  wire                     reset,
    input  wire                     stall,
    input  wire                     redirect,
    input  wire [31:0]              redirect_pc,
    fetch_stage_if_if.master        imem,
    output logic [31:0]             ifid_instr,
    output logic [31:0]             ifid_pc_plus4,
    output logic                    ifid_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    localparam logic [31:0] c_nop        = 32'h0000_0000;
    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_hold_buf;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = redirect_pc & c_align_mask;

    // Request is gated by reset so it drops the instant reset is asserted.
    assign imem.imem_req  = reset && (r_state != S_HOLD);
    assign imem.imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_pc          <= PC_RESET;
            r_drop_addr   <= 32'h0;
            r_hold_buf    <= 32'h0;
            ifid_instr    <= c_nop;
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
        end else if (redirect) begin
            ifid_instr    <= c_nop;
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
            r_pc          <= w_target;
            case (r_state)
                S_FETCH: begin
                    // An unanswered request must still complete; remember its address.
                    if (!imem.imem_ack) begin
                        r_state     <= S_DROP;
                        r_drop_addr <= r_pc;
                    end
                end
                S_HOLD:  r_state <= S_FETCH;
                S_DROP:  r_state <= S_DROP;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        if (stall) begin
                            r_hold_buf <= imem.imem_rdata;
                            r_state    <= S_HOLD;
                        end else begin
                            ifid_instr    <= imem.imem_rdata;
                            ifid_pc_plus4 <= w_pc_plus4;
                            ifid_valid    <= 1'b1;
                            r_pc          <= w_pc_plus4;
                        end
                    end else if (!stall) begin
                        ifid_instr    <= c_nop;
                        ifid_pc_plus4 <= 32'h0;
                        ifid_valid    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_instr    <= r_hold_buf;
                        ifid_pc_plus4 <= w_pc_plus4;
                        ifid_valid    <= 1'b1;
                        r_pc          <= w_pc_plus4;
                        r_state       <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem.imem_ack) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage_if
// Purpose  : Self-checking bench for fetch_stage_if with an in-order scoreboard.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_stage_if;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [31:0] instr2;
    logic [31:0] pc4_2;
    logic        valid2;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;

    int   lat_cfg  = 0;
    bit   rand_lat = 1'b0;
    bit   poison   = 1'b0;
    int   lat_cur  = 0;
    int   wait_cnt = 0;

    always #5 clk = ~clk;

    fetch_stage_if_if bus();
    fetch_stage_if_if bus2();

    fetch_stage_if dut (
        .clock         (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem          (bus),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
    );

    fetch_stage_if #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clock         (clk),
        .reset         (reset),
        .stall         (1'b0),
        .redirect      (1'b0),
        .redirect_pc   (32'h0),
        .imem          (bus2),
        .ifid_instr    (instr2),
        .ifid_pc_plus4 (pc4_2),
        .ifid_valid    (valid2)
    );

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {a[15:0] ^ 16'h1357, a[15:0]};
    endfunction

    // Instruction memory model with programmable latency
    assign bus.imem_ack   = bus.imem_req && (wait_cnt >= lat_cur);
    assign bus.imem_rdata = !bus.imem_ack ? 32'h0BAD_0BAD :
                            (poison && bus.imem_addr == 32'h8) ? 32'hDEAD_BEEF :
                            exp_word(bus.imem_addr);
    assign bus2.imem_ack   = bus2.imem_req;
    assign bus2.imem_rdata = exp_word(bus2.imem_addr);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 0;
            lat_cur  <= lat_cfg;
        end else if (bus.imem_ack) begin
            wait_cnt <= 0;
            lat_cur  <= rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
        end else if (bus.imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ID consumes IF/ID whenever it is valid and not stalled
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (!ifid_valid) begin
                check_eq("bubble_instr", ifid_instr, 32'h0);
            end else if (!stall && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check_eq("ifid_instr", ifid_instr, mon_e.instr);
                check_eq("ifid_pc4", ifid_pc_plus4, mon_e.pc4);
            end
        end
    end

    task automatic push_stream(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.instr = exp_word(start + 32'(4 * i));
            e.pc4   = start + 32'(4 * i + 4);
            sb_q.push_back(e);
        end
    endtask

    task automatic start_test(input int lat, input bit rnd, input bit pois);
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mon_en      = 1'b0;
        sb_q.delete();
        lat_cfg     = lat;
        rand_lat    = rnd;
        poison      = pois;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() > 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check_eq(tag, 32'(sb_q.size()), 32'h0);
        mon_en = 1'b0;
    endtask

    task automatic wait_req_addr(input logic [31:0] a);
        int n = 0;
        while (!(bus.imem_req && bus.imem_addr == a) && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 64) check_eq("wait_addr_timeout", bus.imem_addr, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset values
        #12;
        check_eq("rst_req", 32'(bus.imem_req), 32'h0);
        check_eq("rst_valid", 32'(ifid_valid), 32'h0);
        check_eq("rst_instr", ifid_instr, 32'h0);
        check_eq("rst_pc4", ifid_pc_plus4, 32'h0);
        check_eq("rst_addr", bus.imem_addr, 32'h0);
        check_eq("rst_addr_wrap", bus2.imem_addr, 32'hFFFF_FFFC);
        check_eq("rst_req_wrap", 32'(bus2.imem_req), 32'h0);

        // Zero-wait streaming, plus PC wrap on the second instance
        start_test(0, 1'b0, 1'b0);
        push_stream(32'h0, 6);
        #1;
        check_eq("t1_addr0", bus.imem_addr, 32'h0);
        check_eq("t1_req0", 32'(bus.imem_req), 32'h1);
        check_eq("t6_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check_eq("t1_addr", bus.imem_addr, 32'(4 * k));
            check_eq("t1_pc4", ifid_pc_plus4, 32'(4 * k));
            check_eq("t1_valid", 32'(ifid_valid), 32'h1);
            if (k == 1) begin
                check_eq("t6_addr1", bus2.imem_addr, 32'h0);
                check_eq("t6_pc4", pc4_2, 32'h0);
                check_eq("t6_instr", instr2, exp_word(32'hFFFF_FFFC));
                check_eq("t6_valid", 32'(valid2), 32'h1);
            end
        end
        drain("t1_drain");

        // Two wait cycles before each ack
        start_test(2, 1'b0, 1'b0);
        push_stream(32'h0, 4);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq("t2_wait_valid", 32'(ifid_valid), 32'h0);
            check_eq("t2_wait_instr", ifid_instr, 32'h0);
            check_eq("t2_wait_addr", bus.imem_addr, 32'h0);
            check_eq("t2_wait_req", 32'(bus.imem_req), 32'h1);
            @(posedge clk);
            #1;
        end
        check_eq("t2_valid", 32'(ifid_valid), 32'h1);
        check_eq("t2_instr", ifid_instr, 32'h2008_0005);
        check_eq("t2_pc4", ifid_pc_plus4, 32'h4);
        drain("t2_drain");

        // Stall for three cycles coinciding with the ack of address 8
        start_test(0, 1'b0, 1'b0);
        push_stream(32'h0, 6);
        wait_req_addr(32'h8);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_eq("t3_hold_req", 32'(bus.imem_req), 32'h0);
            check_eq("t3_hold_pc4", ifid_pc_plus4, 32'h8);
            check_eq("t3_hold_valid", 32'(ifid_valid), 32'h1);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        check_eq("t3_rel_req", 32'(bus.imem_req), 32'h0);
        @(posedge clk);
        #1;
        check_eq("t3_next_addr", bus.imem_addr, 32'hC);
        check_eq("t3_next_req", 32'(bus.imem_req), 32'h1);
        check_eq("t3_held_word", ifid_instr, exp_word(32'h8));
        check_eq("t3_held_pc4", ifid_pc_plus4, 32'hC);
        drain("t3_drain");

        // Redirect while address 8 is outstanding; its data is poisoned
        start_test(2, 1'b0, 1'b1);
        push_stream(32'h0, 2);
        push_stream(32'h40, 3);
        wait_req_addr(32'h8);
        check_eq("t4_not_acked", 32'(bus.imem_ack), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        check_eq("t4_drop_addr", bus.imem_addr, 32'h8);
        check_eq("t4_drop_req", 32'(bus.imem_req), 32'h1);
        check_eq("t4_flush_valid", 32'(ifid_valid), 32'h0);
        begin
            int n = 0;
            while (!bus.imem_ack && n < 16) begin
                @(posedge clk);
                #1;
                n++;
            end
            check_eq("t4_drop_ack_seen", 32'(bus.imem_ack), 32'h1);
        end
        @(posedge clk);
        #1;
        check_eq("t4_target_addr", bus.imem_addr, 32'h40);
        drain("t4_drain");

        // Redirect and stall in the same cycle while holding; misaligned target
        start_test(0, 1'b0, 1'b0);
        push_stream(32'h0, 1);
        push_stream(32'h40, 3);
        wait_req_addr(32'h8);
        stall = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_hold_req", 32'(bus.imem_req), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        stall    = 1'b0;
        check_eq("t5_valid", 32'(ifid_valid), 32'h0);
        check_eq("t5_instr", ifid_instr, 32'h0);
        check_eq("t5_addr", bus.imem_addr, 32'h40);
        check_eq("t5_req", 32'(bus.imem_req), 32'h1);
        drain("t5_drain");

        // Random latency with random stalls
        start_test(1, 1'b1, 1'b0);
        push_stream(32'h0, 24);
        begin
            int n = 0;
            while (sb_q.size() > 0 && n < 600) begin
                @(posedge clk);
                #1;
                stall = ($urandom_range(0, 3) == 0);
                n++;
            end
            stall = 1'b0;
        end
        drain("rnd_drain");

        // Asynchronous reset in the middle of a pending request
        start_test(3, 1'b0, 1'b0);
        mon_en = 1'b0;
        wait_req_addr(32'h4);
        stall = 1'b1;
        check_eq("t6_pre_valid", 32'(ifid_valid), 32'h1);
        check_eq("t6_pre_pc4", ifid_pc_plus4, 32'h4);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("t6_arst_req", 32'(bus.imem_req), 32'h0);
        check_eq("t6_arst_valid", 32'(ifid_valid), 32'h0);
        check_eq("t6_arst_instr", ifid_instr, 32'h0);
        check_eq("t6_arst_pc4", ifid_pc_plus4, 32'h0);
        check_eq("t6_arst_addr", bus.imem_addr, 32'h0);
        stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
